sdr_line_server: RTL



---
 rtl/board_pkg.sv | 14 +
 rtl/sdr_line_packer.sv | 27 ++
 rtl/sdr_line_server.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the SDR line server.
package board_pkg;

  localparam int unsigned SDR_LINE_WORDS = 4;
  localparam int unsigned SDR_WORD_BITS  = 16;
  localparam int unsigned SDR_LINE_BITS  = 64;

  typedef enum logic [1:0] {
    SLS_IDLE,
    SLS_FETCH,
    SLS_DONE
  } sls_state_t;

endpackage

// File: rtl/sdr_line_packer.sv
// Word counter plus 4x16 line assembly register; clr restarts a line, load stores word k and steps k.
module sdr_line_packer
  import board_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic [SDR_WORD_BITS-1:0] data,
  output logic [1:0]               k,
  output logic [SDR_LINE_BITS-1:0] line
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k    <= 2'd0;
      line <= '0;
    end else if (clr) begin
      k    <= 2'd0;
      line <= '0;
    end else if (load) begin
      line[{k, 4'b0000} +: SDR_WORD_BITS] <= data;
      k <= k + 2'd1;
    end
  end

endmodule

// File: rtl/sdr_line_server.sv
// 64-bit line read responder: fetches four 16-bit words from a narrow memory port per request.
// Optional ROM_LINE_BUFFER_EN: reuse the last completed line without touching memory.
module sdr_line_server
  import board_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned LINE_WORDS = SDR_LINE_WORDS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        sdr_addr,
  input  logic                     sdr_req,
  output logic                     sdr_rdy,
  output logic [SDR_LINE_BITS-1:0] sdr_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_req,
  input  logic                     mem_ack,
  input  logic [SDR_WORD_BITS-1:0] mem_data,
  input  logic                     buf_flush,
  output logic                     overflow
);

  localparam int unsigned TAG_W  = ADDR_W - 3;
  localparam logic [1:0]  LAST_K = 2'(LINE_WORDS - 1);

  sls_state_t         state;
  logic [TAG_W-1:0]   line_tag;
  logic               pend_valid;
  logic [TAG_W-1:0]   pend_tag;

  logic [TAG_W-1:0]         req_tag_c;
  logic [TAG_W-1:0]         start_tag_c;
  logic                     start_pend_c;
  logic                     start_new_c;
  logic                     start_c;
  logic                     to_slot_c;
  logic                     slot_free_c;
  logic                     load_c;
  logic                     last_c;
  logic                     hit_c;
  logic [1:0]               pk_k;
  logic [SDR_LINE_BITS-1:0] pk_line;
  logic                     unused_bits;

  assign req_tag_c    = sdr_addr[ADDR_W-1:3];
  assign start_pend_c = (state == SLS_IDLE) && pend_valid;
  assign start_new_c  = (state == SLS_IDLE) && !pend_valid && sdr_req;
  assign start_c      = start_pend_c || start_new_c;
  assign start_tag_c  = pend_valid ? pend_tag : req_tag_c;
  // A request not started this cycle needs the slot; it is free if empty or being drained now.
  assign to_slot_c    = sdr_req && !start_new_c;
  assign slot_free_c  = !pend_valid || start_pend_c;
  assign load_c       = (state == SLS_FETCH) && mem_ack;
  assign last_c       = load_c && (pk_k == LAST_K);

`ifdef ROM_LINE_BUFFER_EN
  logic             buf_valid;
  logic [TAG_W-1:0] buf_tag;

  assign hit_c       = buf_valid && (buf_tag == start_tag_c);
  assign unused_bits = ^{sdr_addr[2:0], pk_line[SDR_LINE_BITS-1:SDR_LINE_BITS-SDR_WORD_BITS]};

  // Flush beats a fill landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else if (buf_flush) begin
      buf_valid <= 1'b0;
    end else if (last_c) begin
      buf_valid <= 1'b1;
      buf_tag   <= line_tag;
    end
  end
`else
  assign hit_c       = 1'b0;
  assign unused_bits = ^{sdr_addr[2:0], buf_flush,
                         pk_line[SDR_LINE_BITS-1:SDR_LINE_BITS-SDR_WORD_BITS]};
`endif

  sdr_line_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_c),
    .load    (load_c),
    .data    (mem_data),
    .k       (pk_k),
    .line    (pk_line)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SLS_IDLE;
      line_tag   <= '0;
      pend_valid <= 1'b0;
      pend_tag   <= '0;
      sdr_rdy    <= 1'b0;
      sdr_data   <= '0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (start_pend_c) pend_valid <= 1'b0;
      if (to_slot_c) begin
        if (slot_free_c) begin
          pend_valid <= 1'b1;
          pend_tag   <= req_tag_c;
        end else begin
          overflow <= 1'b1;
        end
      end

      case (state)
        SLS_IDLE: begin
          if (start_c) begin
            line_tag <= start_tag_c;
            if (hit_c) begin
              state <= SLS_DONE;
            end else begin
              state    <= SLS_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= {start_tag_c, 3'b000};
            end
          end
        end
        SLS_FETCH: begin
          if (mem_ack) begin
            if (last_c) begin
              state    <= SLS_DONE;
              mem_req  <= 1'b0;
              sdr_rdy  <= 1'b1;
              sdr_data <= {mem_data, pk_line[SDR_LINE_BITS-SDR_WORD_BITS-1:0]};
            end else begin
              mem_addr <= {line_tag, pk_k + 2'd1, 1'b0};
            end
          end
        end
        SLS_DONE: begin
          // Fetch path enters with sdr_rdy set; a buffer hit raises it one cycle later.
          if (sdr_rdy) begin
            sdr_rdy <= 1'b0;
            state   <= SLS_IDLE;
          end else begin
            sdr_rdy <= 1'b1;
          end
        end
        default: state <= SLS_IDLE;
      endcase
    end
  end

endmodule
